// File: rtl/pwm_gen_multi_if.sv
// Bus bundle for pwm_gen_multi: control/config inputs and PWM outputs.
// POL exists only when PWM_POLARITY_EN is defined.
interface pwm_gen_multi_if #(
    parameter int CH      = 4,
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 12
);
    logic                  EN;
    logic                  LOAD;
    logic [WIDTH-1:0]      PERIOD;
    logic [CH*WIDTH-1:0]   DUTY;
    logic [PRESC_W-1:0]    PRESC;
    logic                  MODE;
`ifdef PWM_POLARITY_EN
    logic [CH-1:0]         POL;
`endif
    logic [CH-1:0]         PWM_OUT;
    logic                  PERIOD_TICK;

    modport master (
`ifdef PWM_POLARITY_EN
        output POL,
`endif
        output EN, LOAD, PERIOD, DUTY, PRESC, MODE,
        input  PWM_OUT, PERIOD_TICK
    );

    modport slave (
`ifdef PWM_POLARITY_EN
        input  POL,
`endif
        input  EN, LOAD, PERIOD, DUTY, PRESC, MODE,
        output PWM_OUT, PERIOD_TICK
    );
endinterface

// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator: shared prescaler and period counter, per-channel duty,
// edge/center-aligned, shadowed config. Optional per-channel polarity: PWM_POLARITY_EN.
module pwm_gen_multi #(
    parameter int CH      = 4,
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 12
) (
    input logic              CLK,
    input logic              RST,
    pwm_gen_multi_if.slave   bus
);
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    dir_t                 dir_q, dir_d;
    logic [PRESC_W-1:0]   psc_q, psc_d, r_act_q, r_act_d, r_pend_q, r_pend_d;
    logic [WIDTH-1:0]     cnt_q, cnt_d, p_act_q, p_act_d, p_pend_q, p_pend_d;
    logic [CH*WIDTH-1:0]  duty_act_q, duty_act_d, duty_pend_q, duty_pend_d;
    logic                 mode_act_q, mode_act_d, mode_pend_q, mode_pend_d;
    logic                 flag_q, flag_d, en_q;
    logic [CH-1:0]        pwm_q, pwm_d, pol;
    logic                 tick_q, tick_d, tick, wrap;

`ifdef PWM_POLARITY_EN
    assign pol = bus.POL;
`else
    assign pol = '0;
`endif

    assign bus.PWM_OUT     = pwm_q;
    assign bus.PERIOD_TICK = tick_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            dir_q       <= DIR_UP;
            psc_q       <= '0;
            cnt_q       <= '0;
            r_act_q     <= '0;
            r_pend_q    <= '0;
            p_act_q     <= '0;
            p_pend_q    <= '0;
            duty_act_q  <= '0;
            duty_pend_q <= '0;
            mode_act_q  <= 1'b0;
            mode_pend_q <= 1'b0;
            flag_q      <= 1'b0;
            en_q        <= 1'b0;
            pwm_q       <= pol;
            tick_q      <= 1'b0;
        end else begin
            dir_q       <= dir_d;
            psc_q       <= psc_d;
            cnt_q       <= cnt_d;
            r_act_q     <= r_act_d;
            r_pend_q    <= r_pend_d;
            p_act_q     <= p_act_d;
            p_pend_q    <= p_pend_d;
            duty_act_q  <= duty_act_d;
            duty_pend_q <= duty_pend_d;
            mode_act_q  <= mode_act_d;
            mode_pend_q <= mode_pend_d;
            flag_q      <= flag_d;
            en_q        <= bus.EN;
            pwm_q       <= pwm_d;
            tick_q      <= tick_d;
        end
    end

    always_comb begin
        dir_d       = dir_q;
        psc_d       = psc_q;
        cnt_d       = cnt_q;
        r_act_d     = r_act_q;
        r_pend_d    = r_pend_q;
        p_act_d     = p_act_q;
        p_pend_d    = p_pend_q;
        duty_act_d  = duty_act_q;
        duty_pend_d = duty_pend_q;
        mode_act_d  = mode_act_q;
        mode_pend_d = mode_pend_q;
        flag_d      = flag_q;
        pwm_d       = pol;
        tick_d      = 1'b0;
        tick        = 1'b0;
        wrap        = 1'b0;

        if (!bus.EN) begin
            psc_d  = '0;
            cnt_d  = '0;
            dir_d  = DIR_UP;
            flag_d = 1'b0;
            if (bus.LOAD) begin
                p_act_d    = bus.PERIOD;
                duty_act_d = bus.DUTY;
                r_act_d    = bus.PRESC;
                mode_act_d = bus.MODE;
            end
        end else begin
            if (bus.LOAD) begin
                p_pend_d    = bus.PERIOD;
                duty_pend_d = bus.DUTY;
                r_pend_d    = bus.PRESC;
                mode_pend_d = bus.MODE;
                flag_d      = 1'b1;
            end
            // First enabled cycle only shows cnt=0; prescaling starts on the next one.
            tick  = en_q && (psc_q == r_act_q);
            psc_d = (tick || !en_q) ? '0 : psc_q + PRESC_W'(1);
            if (tick) begin
                if (p_act_q == '0) begin
                    wrap = 1'b1;
                end else if (!mode_act_q) begin
                    if (cnt_q == p_act_q) wrap = 1'b1;
                    else                  cnt_d = cnt_q + WIDTH'(1);
                end else if (dir_q == DIR_UP) begin
                    // With P=1 the top turnaround already lands on 0, so it is the boundary.
                    if (cnt_q == p_act_q) begin
                        if (p_act_q == WIDTH'(1)) begin
                            wrap = 1'b1;
                        end else begin
                            cnt_d = p_act_q - WIDTH'(1);
                            dir_d = DIR_DOWN;
                        end
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end else begin
                    if (cnt_q == WIDTH'(1)) wrap = 1'b1;
                    else                    cnt_d = cnt_q - WIDTH'(1);
                end
                if (wrap) begin
                    cnt_d  = '0;
                    dir_d  = DIR_UP;
                    tick_d = 1'b1;
                    if (flag_d) begin
                        p_act_d    = p_pend_d;
                        duty_act_d = duty_pend_d;
                        r_act_d    = r_pend_d;
                        mode_act_d = mode_pend_d;
                        flag_d     = 1'b0;
                    end
                end
            end
            for (int unsigned i = 0; i < CH; i++) begin
                pwm_d[i] = (cnt_d < duty_act_d[i*WIDTH +: WIDTH]) ^ pol[i];
            end
        end
    end
endmodule

// File: doc/pwm_gen_multi.md
Name: pwm_gen_multi

Overview:
Parametrised multi-channel PWM generator. It is the successor to the single-channel fixed-divider PWM timer.
- N channels share one programmable prescaler and one period counter; each channel has its own duty compare.
- Supports edge-aligned and center-aligned modes, with glitch-free shadowed updates at period boundaries.
- Sits between the control register block and the motor/LED driver pins of the odometry board.

Parameters:
CH, 4, number of PWM channels (1..16)
WIDTH, 8, period/duty counter width in bits (4..16)
PRESC_W, 12, prescaler reload width in bits (1..16)

Ports:
CLK  input  1  system clock; all logic on posedge CLK
RST  input  1  reset; synchronous, active-high
EN  input  1  counting enable
LOAD  input  1  one-cycle strobe; captures PERIOD, DUTY, PRESC, MODE into pending shadow
PERIOD  input  WIDTH  period limit P
DUTY  input  CH*WIDTH  duty compare; channel i at DUTY[i*WIDTH +: WIDTH]
PRESC  input  PRESC_W  prescaler reload R; tick every R+1 CLK cycles
MODE  input  1  0 = edge-aligned, 1 = center-aligned
PWM_OUT  output  CH  PWM outputs, registered
PERIOD_TICK  output  1  one-cycle pulse at each period boundary, registered

Behaviour:
- Reset: PWM_OUT=0, PERIOD_TICK=0, psc=0, cnt=0, direction=up, pending flag=0. All active registers (P, duty[i], R, mode) are 0. Reset overrides every other input in the same cycle.
- Prescaler:
  - psc counts 0..R_active.
  - tick=1 in the cycle psc==R_active; psc then returns to 0.
  - R=0 gives a tick every cycle.
- Edge mode: on each tick, cnt goes 0,1,..,P,0,... Period is P+1 ticks.
- Center mode: on each tick, cnt goes up to P, then down to 0, then up again. Turnaround values appear once, so the period is 2P ticks.
- P_active==0, either mode: cnt held at 0 and every tick is a boundary.
- Boundary U is the tick on which cnt is loaded with 0 to start a new period:
  - edge mode: cnt==P_active;
  - center mode: cnt==1 and direction=down.
- Compare: invariant while EN=1 (checked every cycle): PWM_OUT[i] == (cnt < duty_active[i]), unsigned.
  - Consequently duty=0 gives constant low.
  - duty>P in edge mode, or duty>=P+1 in center mode, gives constant high.
- Shadow:
  - LOAD copies all inputs to pending and sets the pending flag; multiple LOADs before U mean the last one wins.
  - At U with the flag set, pending is copied to active, the flag clears, and direction is set to up.
  - LOAD in the same cycle as U applies the new values at that U.
- PERIOD_TICK: high exactly one CLK cycle, the cycle after U, i.e. aligned with cnt becoming 0.
- EN=0:
  - psc, cnt and direction are reset to 0/up; PWM_OUT=0; PERIOD_TICK=0.
  - LOAD writes directly to active.
  - On EN rising, the first tick occurs R_active+1 cycles later.
  - PWM_OUT follows the invariant from the first cycle with EN=1, with cnt=0.
- Values changing on PERIOD/DUTY/PRESC/MODE without LOAD have no effect.
- Latency: LOAD to visible output is at most one full period plus 1 cycle.

Optional Feature:
PWM_POLARITY_EN
- Defined: adds input POL [CH-1:0]. PWM_OUT[i] becomes the compare result XOR POL[i], and the idle/disabled/reset level of channel i equals POL[i]. POL is registered directly each cycle, with no shadowing and 1-cycle latency.
- Undefined: there is no POL port and all channels are active-high.

Test Plan:
- CH=4, WIDTH=8, R=0, P=9, edge, DUTY ch0=3, ch1=0, ch2=10, ch3=255, LOAD with EN=0, then EN=1 -> ch0 high 3 of every 10 cycles; ch1 constant 0; ch2 and ch3 constant 1; PERIOD_TICK every 10 cycles.
- Center mode, P=4, duty=2, R=0 -> cnt sequence 0,1,2,3,4,3,2,1; ch high at cnt 0,1 and 1 (3 of 8 cycles); PERIOD_TICK every 8 cycles.
- R=3, P=1, duty=1, edge -> output 4 CLK high then 4 low; tick spacing 4 CLK.
- Running P=9, duty=3; LOAD duty=7 mid-period at cnt=5 -> remainder of period uses duty 3; duty 7 takes effect from cnt=0 aligned with the next PERIOD_TICK. Two LOADs before the boundary -> the second value is used.
- RST asserted mid-period with pending LOAD -> next cycle PWM_OUT=0, cnt=0, pending discarded; after release with EN=1 output stays 0 (all duties 0).
- EN dropped mid-period -> PWM_OUT=0 next cycle. Re-enable -> counting restarts at cnt=0, first PERIOD_TICK after P+1 ticks.
